// File: rtl/imem_fill_unit.sv
// Instruction-memory refill engine: accepts an iCache line request, waits a fixed
// latency, then returns one line with a level ready handshake. Includes a word-write preload port.
module imem_fill_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int MEM_LINES  = 256,
  parameter int LATENCY    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic [LINE_WIDTH-1:0] fill_data,
  output logic                  fill_ready,
  output logic                  busy,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [31:0]           wr_data
);
  localparam int WORDS = LINE_WIDTH / 32;
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(MEM_LINES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic [IDX_W-1:0]        r_line;
  logic [LINE_WIDTH-1:0]   r_fill_data;
  logic                    r_fill_ready;
  logic                    r_busy;
  logic [31:0]             r_mem [MEM_LINES*WORDS];

  logic [IDX_W-1:0]        w_req_line;
  logic [IDX_W+OFF_W-1:0]  w_wr_word;
  logic [LINE_WIDTH-1:0]   w_line_data;
  logic                    w_unused;

  assign w_req_line = req_addr[IDX_W+OFF_W+1:OFF_W+2];
  assign w_wr_word  = wr_addr[IDX_W+OFF_W+1:2];
  assign w_unused   = ^{req_addr[ADDR_WIDTH-1:IDX_W+OFF_W+2], req_addr[OFF_W+1:0],
                        wr_addr[ADDR_WIDTH-1:IDX_W+OFF_W+2], wr_addr[1:0]};

  always_comb begin
    w_line_data = '0;
    for (int k = 0; k < WORDS; k++)
      w_line_data[32*k +: 32] = r_mem[{r_line, OFF_W'(k)}];
  end

  // Memory is never cleared by reset; a same-edge write is not seen by the capture.
  always_ff @(posedge clk) begin
    if (wr_en)
      r_mem[w_wr_word] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_line       <= '0;
      r_fill_data  <= '0;
      r_fill_ready <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req) begin
          r_line  <= w_req_line;
          r_cnt   <= 4'(LATENCY - 1);
          r_state <= S_WAIT;
          r_busy  <= 1'b1;
        end
        S_WAIT: if (r_cnt == 4'd0) begin
          r_fill_data  <= w_line_data;
          r_fill_ready <= 1'b1;
          r_state      <= S_RESP;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
        S_RESP: if (!req) begin
          r_fill_ready <= 1'b0;
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign fill_data  = r_fill_data;
  assign fill_ready = r_fill_ready;
  assign busy       = r_busy;
endmodule

// File: tb/tb_imem_fill_unit.sv
// Directed bench for imem_fill_unit: per-cycle vector table on a LATENCY=5 instance,
// plus a hand sequence on a LATENCY=1 instance.
module tb_imem_fill_unit;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req = 1'b0, req1 = 1'b0;
  logic [31:0]  req_addr = '0, req_addr1 = '0;
  logic         wr_en = 1'b0;
  logic [31:0]  wr_addr = '0, wr_data = '0;
  logic [127:0] fill_data, fill_data1;
  logic         fill_ready, fill_ready1, busy, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_fill_unit #(.LATENCY(5)) dut (
    .clk(clk), .reset(rst), .req(req), .req_addr(req_addr),
    .fill_data(fill_data), .fill_ready(fill_ready), .busy(busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  imem_fill_unit #(.LATENCY(1)) dut1 (
    .clk(clk), .reset(rst), .req(req1), .req_addr(req_addr1),
    .fill_data(fill_data1), .fill_ready(fill_ready1), .busy(busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  typedef struct {
    logic         rst, req;
    logic [31:0]  addr;
    logic         we;
    logic [31:0]  waddr, wdata;
    logic         rdy, bsy;
    logic [127:0] data;
  } vec_t;

  vec_t vecs[$];

  localparam logic [127:0] L1  = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
  localparam logic [127:0] L2  = 128'h2222222C_22222228_22222224_22222220;
  localparam logic [127:0] L2A = 128'h2222222C_22222228_22222224_12345678;
  localparam logic [127:0] L2B = 128'h2222222C_22222228_22222224_00000000;

  task automatic add(input logic r, input logic q, input logic [31:0] a, input logic we,
                     input logic [31:0] wa, input logic [31:0] wd,
                     input logic rdy, input logic bsy, input logic [127:0] d);
    vec_t v;
    v.rst = r; v.req = q; v.addr = a; v.we = we; v.waddr = wa; v.wdata = wd;
    v.rdy = rdy; v.bsy = bsy; v.data = d;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset and preload
    add(1, 0, 0, 0, 0, 0,                 0, 0, '0);
    add(0, 0, 0, 1, 32'h10, 32'hDDDDDDDD, 0, 0, '0);
    add(0, 0, 0, 1, 32'h14, 32'hCCCCCCCC, 0, 0, '0);
    add(0, 0, 0, 1, 32'h18, 32'hBBBBBBBB, 0, 0, '0);
    add(0, 0, 0, 1, 32'h1C, 32'hAAAAAAAA, 0, 0, '0);
    add(0, 0, 0, 1, 32'h20, 32'h22222220, 0, 0, '0);
    add(0, 0, 0, 1, 32'h24, 32'h22222224, 0, 0, '0);
    add(0, 0, 0, 1, 32'h28, 32'h22222228, 0, 0, '0);
    add(0, 0, 0, 1, 32'h2C, 32'h2222222C, 0, 0, '0);
    // basic fill, ready exactly 5 edges after acceptance, then hold in RESP
    add(0, 1, 32'h14, 0, 0, 0, 0, 1, '0);
    for (int i = 0; i < 4; i++) add(0, 1, 32'h14, 0, 0, 0, 0, 1, '0);
    add(0, 1, 32'h14, 0, 0, 0, 1, 1, L1);
    for (int i = 0; i < 3; i++) add(0, 1, 32'h14, 0, 0, 0, 1, 1, L1);
    add(0, 0, 0, 0, 0, 0, 0, 0, L1);
    add(0, 0, 0, 0, 0, 0, 0, 0, L1);
    // reset mid-fill aborts, then a fresh request for line 2
    add(0, 1, 32'h20, 0, 0, 0, 0, 1, L1);
    add(0, 1, 32'h20, 0, 0, 0, 0, 1, L1);
    add(1, 1, 32'h20, 0, 0, 0, 0, 0, '0);
    add(0, 1, 32'h20, 0, 0, 0, 0, 1, '0);
    for (int i = 0; i < 4; i++) add(0, 1, 32'h20, 0, 0, 0, 0, 1, '0);
    add(0, 1, 32'h20, 0, 0, 0, 1, 1, L2);
    add(0, 0, 0, 0, 0, 0, 0, 0, L2);
    // write during WAIT is visible
    add(0, 1, 32'h20, 0, 0, 0, 0, 1, L2);
    add(0, 1, 32'h20, 1, 32'h20, 32'h12345678, 0, 1, L2);
    for (int i = 0; i < 3; i++) add(0, 1, 32'h20, 0, 0, 0, 0, 1, L2);
    add(0, 1, 32'h20, 0, 0, 0, 1, 1, L2A);
    add(0, 0, 0, 0, 0, 0, 0, 0, L2A);
    // write on the capture edge is not visible
    add(0, 1, 32'h20, 0, 0, 0, 0, 1, L2A);
    for (int i = 0; i < 4; i++) add(0, 1, 32'h20, 0, 0, 0, 0, 1, L2A);
    add(0, 1, 32'h20, 1, 32'h20, 32'h0, 1, 1, L2A);
    add(0, 0, 0, 0, 0, 0, 0, 0, L2A);
    // address wrap, and req_addr change during WAIT ignored
    add(0, 1, 32'h1010, 0, 0, 0, 0, 1, L2A);
    for (int i = 0; i < 4; i++) add(0, 1, 32'h30, 0, 0, 0, 0, 1, L2A);
    add(0, 1, 32'h30, 0, 0, 0, 1, 1, L1);
    add(0, 0, 0, 0, 0, 0, 0, 0, L1);
    // req dropped during WAIT still completes; next req=0 edge returns to IDLE
    add(0, 1, 32'h20, 0, 0, 0, 0, 1, L1);
    for (int i = 0; i < 4; i++) add(0, 0, 32'h20, 0, 0, 0, 0, 1, L1);
    add(0, 0, 32'h20, 0, 0, 0, 1, 1, L2B);
    add(0, 0, 32'h20, 0, 0, 0, 0, 0, L2B);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; req = vecs[i].req; req_addr = vecs[i].addr;
      wr_en = vecs[i].we; wr_addr = vecs[i].waddr; wr_data = vecs[i].wdata;
      step();
      check($sformatf("v%0d.ready", i), {127'd0, fill_ready}, {127'd0, vecs[i].rdy});
      check($sformatf("v%0d.busy", i),  {127'd0, busy},       {127'd0, vecs[i].bsy});
      check($sformatf("v%0d.data", i),  fill_data,            vecs[i].data);
    end
    rst = 0; req = 0; wr_en = 0;

    // LATENCY=1 instance: one-edge latency and re-acceptance after one IDLE edge
    req1 = 1; req_addr1 = 32'h10;
    step();
    check("l1.accept_busy",  {127'd0, busy1},       128'd1);
    check("l1.accept_ready", {127'd0, fill_ready1}, 128'd0);
    step();
    check("l1.ready", {127'd0, fill_ready1}, 128'd1);
    check("l1.data",  fill_data1, L1);
    req1 = 0;
    step();
    check("l1.idle_busy",  {127'd0, busy1},       128'd0);
    check("l1.idle_ready", {127'd0, fill_ready1}, 128'd0);
    req1 = 1; req_addr1 = 32'h20;
    step();
    check("l1.reaccept_busy",  {127'd0, busy1},       128'd1);
    check("l1.reaccept_ready", {127'd0, fill_ready1}, 128'd0);
    step();
    check("l1.ready2", {127'd0, fill_ready1}, 128'd1);
    check("l1.data2",  fill_data1, L2B);
    req1 = 0;
    step();
    check("l1.end_busy", {127'd0, busy1}, 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
